alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width; legal values are powers of two, 8 to 64.
REQ-002 SHALL have parameter SW = log2(N), derived, meaning the shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 aluop  input  5  opcode: 00001 ADD, 00010 ADDU, 00011 SUB, 00100 MUL, 00101 SMUL, 00110 DIV, 00111 IDIV, 01000 AND, 01001 OR, 01010 XOR, 01011 NAND, 01100 NOR, 01101 XNOR, 01110 SLL, 01111 SRL, 10000 SAR, 10001 ROR, 10010 ROL.
REQ-008 a, b  input  N  operands; for shifts and rotates the amount is b[SW-1:0].
REQ-009 out_valid  output  1  result and flags are valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 final_sum  output  N  primary result (low product or quotient).
REQ-012 final_hi  output  N  high product or remainder; 0 for other ops.
REQ-013 cout, overflow_flag, negative_flag, zero_flag, div_zero_flag, illegal_flag  output  1 each  status flags.

Function
REQ-014 SHALL implement FSM IDLE/BUSY/DONE; a request is accepted on any edge where in_valid and in_ready are both high; operands and opcode are latched at acceptance.
REQ-015 in_ready SHALL be (state==IDLE) or (state==DONE and out_ready), giving back-to-back acceptance.
REQ-016 Single-cycle ops (all except MUL/SMUL/DIV/IDIV) SHALL go IDLE->DONE; out_valid is high after the edge following acceptance (latency 1).
REQ-017 MUL/SMUL/DIV/IDIV SHALL go IDLE->BUSY, run an iterative N-step shift-add or restoring-divide, then go BUSY->DONE; out_valid is high exactly N+1 edges after acceptance.
REQ-018 In DONE, outputs SHALL be held stable until out_ready is high.
- out_ready with no new request: DONE->IDLE.
- out_ready with a new request: load the new op (single-cycle stays DONE with new result, multi-cycle goes to BUSY).
REQ-019 ADD/ADDU SHALL compute a+b mod 2^N with cout = carry out.
- ADD: overflow_flag = signed overflow.
- ADDU: overflow_flag = cout.
REQ-020 SUB SHALL compute a+~b+1 with cout = carry out (1 = no borrow) and overflow_flag = signed overflow.
REQ-021 MUL (unsigned) SHALL return the 2N-bit product in {final_hi, final_sum} with overflow_flag = (final_hi != 0).
REQ-022 SMUL (signed) SHALL return the 2N-bit product in {final_hi, final_sum} with overflow_flag = 1 when final_hi is not the sign extension of final_sum[N-1].
REQ-023 DIV (unsigned) SHALL return quotient in final_sum and remainder in final_hi; IDIV SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-024 DIV/IDIV with b==0 SHALL return final_sum all-ones, final_hi=a, div_zero_flag=1, and still take N+1 cycles.
REQ-025 IDIV of most-negative by -1 SHALL return final_sum = most-negative, final_hi = 0, overflow_flag = 1.
REQ-026 Logic ops SHALL compute bitwise.
- SLL/SRL: logical shift.
- SAR: arithmetic shift.
- ROR/ROL: rotate.
- A shift or rotate amount of 0 returns a.
- cout = 0 and overflow_flag = 0 for all of these ops.
REQ-027 Undefined opcodes SHALL complete in 1 cycle with final_sum=0, final_hi=0, illegal_flag=1; the flag is otherwise 0.
REQ-028 zero_flag SHALL be (final_sum==0) and negative_flag SHALL be final_sum[N-1], for every op.

Reset
REQ-029 While rst is high, the block SHALL hold state=IDLE, in_ready=0, out_valid=0, and all data/flag outputs and the iteration counter at 0.
REQ-030 rst asserted mid-BUSY or in DONE SHALL abort the operation with no result ever presented.
REQ-031 in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-032 (N=32) ADD a=0xFFFFFF9C, b=50 -> final_sum=0xFFFFFFCE, negative=1, cout=0, overflow=0, out_valid 1 cycle after acceptance.
REQ-033 ADD 0x7FFFFFFF+1 -> final_sum=0x80000000, overflow=1, cout=0; SUB 1-5 with out_ready low 5 cycles -> final_sum=0xFFFFFFFC held stable, cout=0, in_ready=0 throughout.
REQ-034 SMUL a=-3, b=5 -> final_sum=0xFFFFFFF1, final_hi=0xFFFFFFFF, overflow=0, out_valid at acceptance+33.
REQ-035 IDIV a=-7, b=2 -> final_sum=0xFFFFFFFD, final_hi=0xFFFFFFFF; DIV a=9, b=0 -> final_sum=0xFFFFFFFF, final_hi=9, div_zero=1.
REQ-036 Shifts and rotates:
- ROL a=0x80000001, b=1 -> 0x00000003.
- SAR a=0x80000000, b=4 -> 0xF8000000.
- SLL b=32 -> uses amount 0, returns a.
- Back-to-back AND/OR/XOR with out_ready=1 -> one result per cycle.
REQ-037 rst pulse at BUSY cycle 10 of a DIV -> out_valid stays 0, outputs 0, in_ready=1 first cycle after release; a subsequent ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_seq.sv
// Purpose: sequential ALU (add/sub, logic, shifts/rotates, iterative mul/div) behind a valid/ready handshake.
// Latency: 1 cycle for single-cycle ops; N+1 cycles from the accepting cycle for MUL/SMUL/DIV/IDIV.
// Backpressure: result is held in DONE until out_ready; in_ready is IDLE, or DONE with out_ready, for back-to-back issue.
//
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   in_valid/in_ready       : request handshake; aluop, a, b are captured on acceptance
//   out_valid/out_ready     : result handshake
//   final_sum, final_hi     : low result (sum/low product/quotient), high result (high product/remainder)
//   cout, overflow_flag, negative_flag, zero_flag, div_zero_flag, illegal_flag : status flags
module alu_seq #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   aluop,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] final_sum,
    output logic [N-1:0] final_hi,
    output logic         cout,
    output logic         overflow_flag,
    output logic         negative_flag,
    output logic         zero_flag,
    output logic         div_zero_flag,
    output logic         illegal_flag
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_ADDU = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_MUL  = 5'b00100;
    localparam logic [4:0] OP_SMUL = 5'b00101;
    localparam logic [4:0] OP_DIV  = 5'b00110;
    localparam logic [4:0] OP_IDIV = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_XOR  = 5'b01010;
    localparam logic [4:0] OP_NAND = 5'b01011;
    localparam logic [4:0] OP_NOR  = 5'b01100;
    localparam logic [4:0] OP_XNOR = 5'b01101;
    localparam logic [4:0] OP_SLL  = 5'b01110;
    localparam logic [4:0] OP_SRL  = 5'b01111;
    localparam logic [4:0] OP_SAR  = 5'b10000;
    localparam logic [4:0] OP_ROR  = 5'b10001;
    localparam logic [4:0] OP_ROL  = 5'b10010;

    // Iteration index of the final step; the last step also produces the result.
    localparam logic [SW-1:0] CNT_LAST = SW'(N - 1);
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);
    localparam logic [N-1:0]  MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef struct packed {
        logic [N-1:0] sum;
        logic [N-1:0] hi;
        logic         cout;
        logic         ovf;
        logic         neg;
        logic         zero;
        logic         dz;
        logic         ill;
    } res_t;

    // Negative/zero are derived from the low result for every op.
    function automatic res_t make_res(input logic [N-1:0] sum, input logic [N-1:0] hi,
                                      input logic c, input logic v,
                                      input logic dz, input logic ill);
        res_t r;
        r.sum  = sum;
        r.hi   = hi;
        r.cout = c;
        r.ovf  = v;
        r.neg  = sum[N-1];
        r.zero = (sum == '0);
        r.dz   = dz;
        r.ill  = ill;
        return r;
    endfunction

    logic [1:0]    state;
    logic [4:0]    op_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  opnd;       // multiplicand or divisor magnitude
    logic [N-1:0]  work_hi;    // partial product high half / partial remainder
    logic [N-1:0]  work_lo;    // multiplier bits / dividend bits turning into quotient
    logic          neg_q;      // negate product or quotient at the end
    logic          neg_rem_q;  // negate remainder (dividend was negative)
    logic [SW-1:0] cnt;
    res_t          res_q;

    logic accept;
    assign in_ready  = ~rst & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid & in_ready;

    // ---------------- single-cycle datapath ----------------
    logic [SW-1:0] shamt;
    logic [N:0]    add_ext;
    logic [N:0]    sub_ext;
    logic [N-1:0]  sc_sum;
    logic          sc_cout;
    logic          sc_ovf;
    logic          sc_ill;
    res_t          sc_res;

    assign shamt   = b[SW-1:0];
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};

    always_comb begin
        sc_sum  = '0;
        sc_cout = 1'b0;
        sc_ovf  = 1'b0;
        sc_ill  = 1'b0;
        case (aluop)
            OP_ADD: begin
                sc_sum  = add_ext[N-1:0];
                sc_cout = add_ext[N];
                sc_ovf  = (a[N-1] == b[N-1]) && (add_ext[N-1] != a[N-1]);
            end
            OP_ADDU: begin
                sc_sum  = add_ext[N-1:0];
                sc_cout = add_ext[N];
                sc_ovf  = add_ext[N];
            end
            OP_SUB: begin
                sc_sum  = sub_ext[N-1:0];
                sc_cout = sub_ext[N];
                sc_ovf  = (a[N-1] != b[N-1]) && (sub_ext[N-1] != a[N-1]);
            end
            OP_AND:  sc_sum = a & b;
            OP_OR:   sc_sum = a | b;
            OP_XOR:  sc_sum = a ^ b;
            OP_NAND: sc_sum = ~(a & b);
            OP_NOR:  sc_sum = ~(a | b);
            OP_XNOR: sc_sum = ~(a ^ b);
            OP_SLL:  sc_sum = a << shamt;
            OP_SRL:  sc_sum = a >> shamt;
            OP_SAR:  sc_sum = $signed(a) >>> shamt;
            // A shift by N yields zero, so amount 0 leaves a unchanged.
            OP_ROR:  sc_sum = (a >> shamt) | (a << (N - int'(shamt)));
            OP_ROL:  sc_sum = (a << shamt) | (a >> (N - int'(shamt)));
            OP_MUL, OP_SMUL, OP_DIV, OP_IDIV: sc_sum = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    assign sc_res = make_res(sc_sum, '0, sc_cout, sc_ovf, 1'b0, sc_ill);

    // ---------------- iterative operand preparation ----------------
    logic         multi_in;
    logic         mul_in;
    logic         signed_in;
    logic         a_neg;
    logic         b_neg;
    logic [N-1:0] a_mag;
    logic [N-1:0] b_mag;

    assign mul_in    = (aluop == OP_MUL) || (aluop == OP_SMUL);
    assign multi_in  = mul_in || (aluop == OP_DIV) || (aluop == OP_IDIV);
    assign signed_in = (aluop == OP_SMUL) || (aluop == OP_IDIV);
    assign a_neg     = signed_in & a[N-1];
    assign b_neg     = signed_in & b[N-1];
    // Signed ops run on magnitudes; the sign is restored in the final step.
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // ---------------- one shift-add / restoring-divide step ----------------
    logic         is_mul_q;
    logic [N:0]   mul_acc;
    logic [N:0]   div_shift;
    logic [N:0]   div_trial;
    logic         div_ok;
    logic [N-1:0] step_hi;
    logic [N-1:0] step_lo;

    assign is_mul_q  = (op_q == OP_MUL) || (op_q == OP_SMUL);
    assign mul_acc   = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opnd : {N{1'b0}})};
    assign div_shift = {work_hi, work_lo[N-1]};
    assign div_trial = div_shift - {1'b0, opnd};
    assign div_ok    = ~div_trial[N];

    always_comb begin
        if (is_mul_q) begin
            step_hi = mul_acc[N:1];
            step_lo = {mul_acc[0], work_lo[N-1:1]};
        end else begin
            step_hi = div_ok ? div_trial[N-1:0] : div_shift[N-1:0];
            step_lo = {work_lo[N-2:0], div_ok};
        end
    end

    // ---------------- result of the last step ----------------
    logic [2*N-1:0] prod_s;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;
    logic           idiv_ovf;
    res_t           fin_res;

    assign prod_s   = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    assign quo      = neg_q ? -step_lo : step_lo;
    assign rem      = neg_rem_q ? -step_hi : step_hi;
    // Most-negative / -1: the magnitude path already yields MOST_NEG rem 0; only the flag is special.
    assign idiv_ovf = (op_q == OP_IDIV) && (a_q == MOST_NEG) && (b_q == {N{1'b1}});

    always_comb begin
        fin_res = '0;
        case (op_q)
            OP_MUL:  fin_res = make_res(step_lo, step_hi, 1'b0, (step_hi != '0), 1'b0, 1'b0);
            OP_SMUL: fin_res = make_res(prod_s[N-1:0], prod_s[2*N-1:N], 1'b0,
                                        (prod_s[2*N-1:N] != {N{prod_s[N-1]}}), 1'b0, 1'b0);
            OP_DIV, OP_IDIV: begin
                if (b_q == '0)
                    fin_res = make_res({N{1'b1}}, a_q, 1'b0, 1'b0, 1'b1, 1'b0);
                else
                    fin_res = make_res(quo, rem, 1'b0, idiv_ovf, 1'b0, 1'b0);
            end
            default: fin_res = '0;
        endcase
    end

    // ---------------- control and state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd      <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt       <= '0;
            res_q     <= '0;
        end else if (accept) begin
            op_q <= aluop;
            a_q  <= a;
            b_q  <= b;
            cnt  <= '0;
            if (multi_in) begin
                state     <= S_BUSY;
                work_hi   <= '0;
                work_lo   <= mul_in ? b_mag : a_mag;
                opnd      <= mul_in ? a_mag : b_mag;
                neg_q     <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
            end else begin
                state <= S_DONE;
                res_q <= sc_res;
            end
        end else if (state == S_BUSY) begin
            work_hi <= step_hi;
            work_lo <= step_lo;
            if (cnt == CNT_LAST) begin
                state <= S_DONE;
                res_q <= fin_res;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end else if ((state == S_DONE) && out_ready) begin
            state <= S_IDLE;
        end
    end

    assign final_sum     = res_q.sum;
    assign final_hi      = res_q.hi;
    assign cout          = res_q.cout;
    assign overflow_flag = res_q.ovf;
    assign negative_flag = res_q.neg;
    assign zero_flag     = res_q.zero;
    assign div_zero_flag = res_q.dz;
    assign illegal_flag  = res_q.ill;

endmodule

// File: tb/tb_alu_seq.sv
// Purpose: self-checking bench for alu_seq (N=32): directed vectors, scoreboard queue, separate monitor.
// Latency: checks 1-cycle and N+1-cycle result timing, hold under backpressure, reset abort.
// Backpressure: out_ready held low for five cycles around one SUB; otherwise the consumer is always ready.
module tb_alu_seq;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_ADDU = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_MUL  = 5'b00100;
    localparam logic [4:0] OP_SMUL = 5'b00101;
    localparam logic [4:0] OP_DIV  = 5'b00110;
    localparam logic [4:0] OP_IDIV = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_XOR  = 5'b01010;
    localparam logic [4:0] OP_NAND = 5'b01011;
    localparam logic [4:0] OP_NOR  = 5'b01100;
    localparam logic [4:0] OP_XNOR = 5'b01101;
    localparam logic [4:0] OP_SLL  = 5'b01110;
    localparam logic [4:0] OP_SRL  = 5'b01111;
    localparam logic [4:0] OP_SAR  = 5'b10000;
    localparam logic [4:0] OP_ROR  = 5'b10001;
    localparam logic [4:0] OP_ROL  = 5'b10010;

    // flags = {cout, overflow, negative, zero, div_zero, illegal}
    typedef struct packed {
        logic [31:0] sum;
        logic [31:0] hi;
        logic [5:0]  fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] final_sum;
    logic [31:0] final_hi;
    logic        cout;
    logic        overflow_flag;
    logic        negative_flag;
    logic        zero_flag;
    logic        div_zero_flag;
    logic        illegal_flag;

    int   vecs = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t sb[$];
    string nm_q[$];

    alu_seq #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .final_sum(final_sum), .final_hi(final_hi),
        .cout(cout), .overflow_flag(overflow_flag), .negative_flag(negative_flag),
        .zero_flag(zero_flag), .div_zero_flag(div_zero_flag), .illegal_flag(illegal_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] s, input logic [31:0] h, input logic [5:0] f);
        exp_t e;
        e.sum = s;
        e.hi  = h;
        e.fl  = f;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] expv);
        vecs++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input string nm, input logic [4:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input exp_t e, input bit push, output int acc);
        int guard;
        in_valid = 1'b1;
        aluop    = op;
        a        = av;
        b        = bv;
        guard    = 0;
        acc      = -1;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            vecs++;
            miscompares++;
            $display("FAIL %s_accept: in_ready stayed 0, expected 1 within 300 cycles", nm);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end else begin
            if (push) begin
                sb.push_back(e);
                nm_q.push_back(nm);
            end
            @(posedge clk);
            #1;
            acc      = cyc;
            in_valid = 1'b0;
        end
    endtask

    // Cycles from the accepting cycle until out_valid is seen (1 = next cycle).
    task automatic meas_lat(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain;
        int g;
        g = 0;
        while (out_valid && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
    endtask

    // Monitor: every transfer pops one expected entry.
    initial begin
        exp_t  got;
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                got = {final_sum, final_hi, cout, overflow_flag, negative_flag,
                       zero_flag, div_zero_flag, illegal_flag};
                vecs++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: got sum=%h hi=%h fl=%b, expected no output",
                             got.sum, got.hi, got.fl);
                end else begin
                    e  = sb.pop_front();
                    nm = nm_q.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL %s: got sum=%h hi=%h fl=%b, expected sum=%h hi=%h fl=%b",
                                 nm, got.sum, got.hi, got.fl, e.sum, e.hi, e.fl);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc0, acc1, acc2, lat, g, seen;
        exp_t dummy;
        dummy     = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        aluop     = '0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {in_ready, out_valid, final_sum, final_hi, cout, overflow_flag,
                            negative_flag, zero_flag, div_zero_flag, illegal_flag}, 72'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Arithmetic, single cycle
        send("add_neg", OP_ADD, 32'hFFFFFF9C, 32'd50, mk(32'hFFFFFFCE, 0, 6'b001000), 1, acc0);
        meas_lat(lat);
        chk("add_latency", lat, 1);
        send("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'd1, mk(32'h80000000, 0, 6'b011000), 1, acc0);
        send("addu_carry", OP_ADDU, 32'hFFFFFFFF, 32'd1, mk(32'h0, 0, 6'b110100), 1, acc0);
        send("sub_zero", OP_SUB, 32'd5, 32'd5, mk(32'h0, 0, 6'b100100), 1, acc0);

        // SUB held under backpressure
        drain();
        out_ready = 1'b0;
        send("sub_hold", OP_SUB, 32'd1, 32'd5, mk(32'hFFFFFFFC, 0, 6'b001000), 1, acc0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sub_hold_stable", {out_valid, in_ready, final_sum, cout}, {1'b1, 1'b0, 32'hFFFFFFFC, 1'b0});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Iterative ops
        send("smul", OP_SMUL, 32'hFFFFFFFD, 32'd5, mk(32'hFFFFFFF1, 32'hFFFFFFFF, 6'b001000), 1, acc0);
        meas_lat(lat);
        chk("smul_latency", lat, 33);
        send("mul_ovf", OP_MUL, 32'h00010000, 32'h00010000, mk(32'h0, 32'h1, 6'b010100), 1, acc0);
        send("idiv_neg", OP_IDIV, 32'hFFFFFFF9, 32'd2, mk(32'hFFFFFFFD, 32'hFFFFFFFF, 6'b001000), 1, acc0);
        send("idiv_negdiv", OP_IDIV, 32'd7, 32'hFFFFFFFE, mk(32'hFFFFFFFD, 32'h1, 6'b001000), 1, acc0);
        send("div_zero", OP_DIV, 32'd9, 32'd0, mk(32'hFFFFFFFF, 32'd9, 6'b001010), 1, acc0);
        meas_lat(lat);
        chk("div_zero_latency", lat, 33);
        send("div", OP_DIV, 32'd100, 32'd7, mk(32'hE, 32'h2, 6'b000000), 1, acc0);
        send("idiv_minneg", OP_IDIV, 32'h80000000, 32'hFFFFFFFF, mk(32'h80000000, 32'h0, 6'b011000), 1, acc0);

        // Shifts and rotates
        send("rol", OP_ROL, 32'h80000001, 32'd1, mk(32'h3, 0, 6'b000000), 1, acc0);
        send("sar", OP_SAR, 32'h80000000, 32'd4, mk(32'hF8000000, 0, 6'b001000), 1, acc0);
        send("sll_32", OP_SLL, 32'h12345678, 32'd32, mk(32'h12345678, 0, 6'b000000), 1, acc0);
        send("ror", OP_ROR, 32'h00000001, 32'd4, mk(32'h10000000, 0, 6'b000000), 1, acc0);
        send("srl", OP_SRL, 32'hF0000000, 32'd28, mk(32'hF, 0, 6'b000000), 1, acc0);

        // Back-to-back logic ops
        send("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'hF000F000, 0, 6'b001000), 1, acc0);
        send("or",  OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, mk(32'hFFF0FFF0, 0, 6'b001000), 1, acc1);
        send("xor", OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, mk(32'h0FF00FF0, 0, 6'b000000), 1, acc2);
        chk("b2b_gap_1", acc1 - acc0, 1);
        chk("b2b_gap_2", acc2 - acc1, 1);
        send("nand", OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'h0, 0, 6'b000100), 1, acc0);
        send("nor",  OP_NOR,  32'h0, 32'h0, mk(32'hFFFFFFFF, 0, 6'b001000), 1, acc0);
        send("xnor", OP_XNOR, 32'hA5A5A5A5, 32'hA5A5A5A5, mk(32'hFFFFFFFF, 0, 6'b001000), 1, acc0);

        // Undefined opcodes
        send("illegal_13", 5'b10011, 32'h1234, 32'h5678, mk(32'h0, 0, 6'b000101), 1, acc0);
        meas_lat(lat);
        chk("illegal_latency", lat, 1);
        send("illegal_00", 5'b00000, 32'hFFFF, 32'h1, mk(32'h0, 0, 6'b000101), 1, acc0);

        // Reset in the middle of a DIV
        drain();
        send("div_abort", OP_DIV, 32'd100, 32'd7, dummy, 0, acc0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_in_reset", {out_valid, in_ready, final_sum, final_hi}, 66'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", {in_ready, out_valid}, 2'b10);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        @(posedge clk);
        #1;
        send("add_after_abort", OP_ADD, 32'd2, 32'd3, mk(32'd5, 0, 6'b000000), 1, acc0);
        meas_lat(lat);
        chk("add_after_abort_latency", lat, 1);

        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        chk("scoreboard_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
